move_executor: RTL and testbench
================================

// Module: move_executor
// PURPOSE
//  Consumer end of the movement-code interface driven by the button FSM.
//  Decodes the 3-bit movement code and applies one slide-and-merge pass to a
//  4x4 board of log2 tiles. Raises the sticky win flag that feeds back into the FSM.
//  Sits between the button FSM and the display/tile-spawn logic.
// PARAMETERS
//  WIN_EXP  11  tile exponent that sets win (2^11 = 2048)
//  SCORE_W  20  score register width; arithmetic wraps modulo 2^SCORE_W
// PORTS
//  clk       in   1   system clock
//  rst       in   1   synchronous, active-high reset
//  movement  in   3   movement code from FSM (level, held while button held)
//  wr_en     in   1   tile write strobe (spawn logic)
//  wr_idx    in   4   cell index r*4+c for the write
//  wr_val    in   4   tile exponent to write (0 = empty)
//  board     out  64  cell idx occupies bits [4*idx +: 4]
//  score     out  SCORE_W  accumulated score
//  busy      out  1   move in progress
//  done      out  1   one-cycle pulse when a move completes
//  moved     out  1   valid with done: at least one cell changed
//  win       out  1   sticky; cleared only by rst
// BEHAVIOUR
//  - Reset: board=0, score=0, busy=0, done=0, moved=0, win=0, mv_prev=000, state S_IDLE.
//  - Codes: 000 none, 001 LEFT, 010 RIGHT, 011 UP, 100 DOWN, 101 WIN-lock; 101/110/111 never start a move.
//  - S_IDLE accepts a move when movement is in 001..100, movement != mv_prev, win=0 and wr_en=0.
//    mv_prev updates only in S_IDLE when wr_en=0, so a held code executes once.
//    A code that changes during busy is accepted after the move completes.
//  - wr_en is honoured only in S_IDLE and takes priority in that cycle. Move acceptance is
//    deferred one cycle; wr_en is ignored while busy.
//  - Timing: accept at cycle T -> S_LINE at T+1..T+4, one line per cycle, busy=1.
//    Line i is written at the end of each of these cycles.
//    S_DONE at T+5 asserts done=1 and moved (busy=0), then returns to S_IDLE.
//  - Line i, element 0 first: LEFT = row i, c=0..3; RIGHT = row i, c=3..0;
//    UP = col i, r=0..3; DOWN = col i, r=3..0.
//  - Merge: compact non-zero tiles toward element 0. Scan from element 0 and merge equal
//    adjacent pairs once each into k+1; 15 saturates (no merge).
//    Each merge adds 2^(k+1) to score.
//  - win sets at S_DONE if any cell >= WIN_EXP. While win=1, no moves are accepted.
//  - rst mid-move aborts immediately to the reset state; partial results are discarded.
// CONFIGURATION
//  MOVE_EXEC_UNDO_EN defined:
//    - Adds input port undo (1 bit).
//    - Snapshots board and score at each move acceptance.
//    - An undo pulse in S_IDLE with a valid snapshot restores both values and
//      invalidates the snapshot; only one level of undo exists.
//    - undo outranks wr_en and move acceptance.
//    - rst invalidates the snapshot.
//  MOVE_EXEC_UNDO_EN undefined: no undo port and no snapshot registers.
// STRUCTURE
//  game_pkg:
//    - movement_t enum (MV_NONE, MV_LEFT, MV_RIGHT, MV_UP, MV_DOWN, MV_WIN)
//    - tile_t = logic [3:0]
//    - constants GRID_N=4 and CELLS=16
//  line_merge: combinational sub-module. Inputs: 4 x tile_t. Outputs: 4 x tile_t,
//    score increment, changed flag. It is instantiated once and shared across S_LINE cycles.
// TESTING
//  1. rst=1 for 1 cycle -> board=0, score=0, busy=0, done=0, moved=0, win=0.
//  2. Write cells 0..3 = 1,1,2,0; movement=001 -> busy 4 cycles, done at T+5;
//     cells 0..3 = 2,2,0,0; score=4; moved=1.
//  3. Hold 001 for 10 more cycles -> no done. Then 010 -> cells 0..3 = 0,0,0,3; score=12.
//  4. Cells 0,4,8,12 = 1,0,1,1; movement=011 -> cells 0,4,8,12 = 2,1,0,0; score += 4.
//  5. Cells 0,1 = 10,10; movement=001 -> cell0=11, win=1. Later codes -> no done.
//     rst -> win=0.
//  6. wr_en coincident with a new code -> write lands; move done at T+6.
//     With MOVE_EXEC_UNDO_EN: undo after test 2 -> cells 0..3 = 1,1,2,0; score=0.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: types and constants shared by the move executor and its line merger.
//   movement_t  : 3-bit movement code (LEFT/RIGHT/UP/DOWN, WIN-lock)
//   tile_t      : log2 tile exponent, 0 = empty cell
//   GRID_N/CELLS: board geometry
//   cell_index(): maps (direction, line, element) to a board cell index r*4+c,
//                 element 0 being the cell tiles slide towards.
package game_pkg;

  localparam int GRID_N = 4;
  localparam int CELLS  = 16;

  typedef logic [3:0] tile_t;

  typedef enum logic [2:0] {
    MV_NONE  = 3'd0,
    MV_LEFT  = 3'd1,
    MV_RIGHT = 3'd2,
    MV_UP    = 3'd3,
    MV_DOWN  = 3'd4,
    MV_WIN   = 3'd5
  } movement_t;

  function automatic logic [3:0] cell_index(input movement_t dir,
                                            input logic [1:0] line,
                                            input logic [1:0] elem);
    logic [1:0] r;
    logic [1:0] c;
    // For 2-bit values, 3 - x is simply ~x.
    case (dir)
      MV_LEFT:  begin r = line;  c = elem;  end
      MV_RIGHT: begin r = line;  c = ~elem; end
      MV_UP:    begin r = elem;  c = line;  end
      MV_DOWN:  begin r = ~elem; c = line;  end
      default:  begin r = line;  c = elem;  end
    endcase
    return {r, c};
  endfunction

endpackage

// File: rtl/line_merge.sv
// line_merge: combinational slide-and-merge of one 4-tile line toward element 0.
//   line_in   : 4 tiles, element 0 first
//   line_out  : compacted and merged tiles
//   score_inc : sum of 2^(k+1) over every merge producing tile k+1
//   changed   : line_out differs from line_in
// Equal adjacent pairs merge once each, scanning from element 0; exponent 15
// saturates and never merges.
module line_merge
  import game_pkg::*;
(
  input  tile_t [GRID_N-1:0] line_in,
  output tile_t [GRID_N-1:0] line_out,
  output logic  [16:0]       score_inc,
  output logic               changed
);

  // One spare zero slot past the end lets the pair compare read comp[i+1]
  // uniformly; a real tile never equals that zero.
  tile_t [GRID_N:0] comp;
  logic  [2:0]      cnt;
  logic  [2:0]      oc;
  logic             skip;

  always_comb begin
    comp = '0;
    cnt  = 3'd0;
    for (int i = 0; i < GRID_N; i++) begin
      if (line_in[i] != 4'd0) begin
        comp[cnt] = line_in[i];
        cnt       = cnt + 3'd1;
      end
    end

    line_out  = '0;
    score_inc = 17'd0;
    oc        = 3'd0;
    skip      = 1'b0;
    for (int i = 0; i < GRID_N; i++) begin
      if (skip) begin
        skip = 1'b0;
      end else if (comp[i] != 4'd0) begin
        if ((comp[i] == comp[i+1]) && (comp[i] != 4'hF)) begin
          line_out[oc[1:0]] = comp[i] + 4'd1;
          score_inc         = score_inc + (17'd1 << (comp[i] + 4'd1));
          skip              = 1'b1;
        end else begin
          line_out[oc[1:0]] = comp[i];
        end
        oc = oc + 3'd1;
      end
    end

    changed = (line_out != line_in);
  end

endmodule

// File: rtl/move_executor.sv
// move_executor: applies one slide-and-merge pass per accepted movement code to
// a 4x4 board of log2 tiles, one line per cycle through a shared line_merge.
//   clk, rst        : clock, synchronous active-high reset
//   movement        : 3-bit movement code (level)
//   wr_en/idx/val   : tile write from the spawn logic (idle only)
//   undo            : present only with MOVE_EXEC_UNDO_EN; restores last snapshot
//   board           : cell idx at bits [4*idx +: 4]
//   score           : accumulated score, wraps modulo 2^SCORE_W
//   busy/done/moved : move in progress / completion pulse / board changed
//   win             : sticky, set when a finished move leaves a tile >= WIN_EXP
// Optional feature macro: MOVE_EXEC_UNDO_EN (one-level undo of board and score).
module move_executor
  import game_pkg::*;
#(
  parameter int unsigned WIN_EXP = 11,
  parameter int unsigned SCORE_W = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         movement,
  input  logic               wr_en,
  input  logic [3:0]         wr_idx,
  input  logic [3:0]         wr_val,
`ifdef MOVE_EXEC_UNDO_EN
  input  logic               undo,
`endif
  output logic [63:0]        board,
  output logic [SCORE_W-1:0] score,
  output logic               busy,
  output logic               done,
  output logic               moved,
  output logic               win
);

  typedef enum logic [1:0] {S_IDLE, S_LINE, S_DONE} state_t;

  state_t            state;
  tile_t             cells [CELLS];
  movement_t         dir;
  logic [1:0]        line_idx;
  logic [2:0]        mv_prev;
  logic              moved_acc;

  tile_t [GRID_N-1:0] line_in;
  tile_t [GRID_N-1:0] line_out;
  logic  [16:0]       score_inc;
  logic               line_changed;
  logic [CELLS-1:0]   cell_win;
  logic               undo_req;
  logic               accept;

  genvar gi;
  generate
    for (gi = 0; gi < CELLS; gi++) begin : g_cells
      assign board[4*gi +: 4] = cells[gi];
      assign cell_win[gi]     = (32'(cells[gi]) >= WIN_EXP);
    end
    for (gi = 0; gi < GRID_N; gi++) begin : g_line
      assign line_in[gi] = cells[cell_index(dir, line_idx, 2'(gi))];
    end
  endgenerate

  line_merge u_line_merge (
    .line_in   (line_in),
    .line_out  (line_out),
    .score_inc (score_inc),
    .changed   (line_changed)
  );

`ifdef MOVE_EXEC_UNDO_EN
  tile_t              snap_cells [CELLS];
  logic [SCORE_W-1:0] snap_score;
  logic               snap_valid;

  assign undo_req = (state == S_IDLE) && undo && snap_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      snap_valid <= 1'b0;
    end else if (accept) begin
      snap_cells <= cells;
      snap_score <= score;
      snap_valid <= 1'b1;
    end else if (undo_req) begin
      snap_valid <= 1'b0;
    end
  end
`else
  assign undo_req = 1'b0;
`endif

  // Undo and tile writes both outrank a new move; the move is simply seen
  // again next cycle because mv_prev is not updated in those cycles.
  assign accept = (state == S_IDLE) && !undo_req && !wr_en && !win &&
                  (movement >= 3'd1) && (movement <= 3'd4) &&
                  (movement != mv_prev);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      for (int j = 0; j < CELLS; j++) cells[j] <= 4'd0;
      score     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      moved     <= 1'b0;
      win       <= 1'b0;
      mv_prev   <= 3'd0;
      dir       <= MV_NONE;
      line_idx  <= 2'd0;
      moved_acc <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (undo_req) begin
`ifdef MOVE_EXEC_UNDO_EN
            cells <= snap_cells;
            score <= snap_score;
`endif
          end else if (wr_en) begin
            cells[wr_idx] <= wr_val;
          end else begin
            mv_prev <= movement;
            if (accept) begin
              dir       <= movement_t'(movement);
              line_idx  <= 2'd0;
              moved_acc <= 1'b0;
              moved     <= 1'b0;
              busy      <= 1'b1;
              state     <= S_LINE;
            end
          end
        end
        S_LINE: begin
          for (int e = 0; e < GRID_N; e++) begin
            cells[cell_index(dir, line_idx, 2'(e))] <= line_out[e];
          end
          score     <= score + SCORE_W'(score_inc);
          moved_acc <= moved_acc | line_changed;
          line_idx  <= line_idx + 2'd1;
          if (line_idx == 2'd3) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            moved <= moved_acc | line_changed;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (|cell_win) win <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_move_executor.sv
// Scoreboard bench for move_executor: stimulus pushes the expected result of
// every accepted move (board, score, moved, completion cycle); a monitor pops
// and compares on each done pulse. The reference model works on whole lines
// with queues.
module tb_move_executor;
  import game_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  movement;
  logic        wr_en;
  logic [3:0]  wr_idx;
  logic [3:0]  wr_val;
  logic [63:0] board;
  logic [19:0] score;
  logic        busy, done, moved, win;
`ifdef MOVE_EXEC_UNDO_EN
  logic        undo;
`endif

  always #5 clk = ~clk;

  move_executor #(.WIN_EXP(11), .SCORE_W(20)) dut (
    .clk      (clk),
    .rst      (rst),
    .movement (movement),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_val   (wr_val),
`ifdef MOVE_EXEC_UNDO_EN
    .undo     (undo),
`endif
    .board    (board),
    .score    (score),
    .busy     (busy),
    .done     (done),
    .moved    (moved),
    .win      (win)
  );

  typedef struct {
    logic [63:0] board;
    int          score;
    logic        moved;
    int          done_cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  int   m_board [16];
  int   m_score;
  int   m_prev;
  bit   m_win;
`ifdef MOVE_EXEC_UNDO_EN
  int   s_board [16];
  int   s_score;
  bit   s_valid;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [63:0] model_board();
    logic [63:0] b;
    b = '0;
    for (int j = 0; j < 16; j++) b[4*j +: 4] = 4'(m_board[j]);
    return b;
  endfunction

  // Whole-board move in the reference model: per line, drop empties, merge
  // equal neighbours once from the front, pad with empties.
  function automatic bit model_move(input int code);
    bit changed;
    changed = 1'b0;
    for (int ln = 0; ln < 4; ln++) begin
      int idx [4];
      int q[$];
      int outl[$];
      for (int e = 0; e < 4; e++) begin
        int r, c;
        case (code)
          1: begin r = ln;    c = e;     end
          2: begin r = ln;    c = 3 - e; end
          3: begin r = e;     c = ln;    end
          default: begin r = 3 - e; c = ln; end
        endcase
        idx[e] = r * 4 + c;
        if (m_board[idx[e]] != 0) q.push_back(m_board[idx[e]]);
      end
      while (q.size() > 0) begin
        int a;
        a = q.pop_front();
        if (q.size() > 0 && q[0] == a && a != 15) begin
          void'(q.pop_front());
          outl.push_back(a + 1);
          m_score = (m_score + (1 << (a + 1))) & ((1 << 20) - 1);
        end else begin
          outl.push_back(a);
        end
      end
      while (outl.size() < 4) outl.push_back(0);
      for (int e = 0; e < 4; e++) begin
        if (m_board[idx[e]] != outl[e]) changed = 1'b1;
        m_board[idx[e]] = outl[e];
      end
    end
    return changed;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    movement = 3'd0;
    wr_en = 1'b0;
`ifdef MOVE_EXEC_UNDO_EN
    undo = 1'b0;
    s_valid = 1'b0;
`endif
    tick();
    rst = 1'b0;
    exp_q.delete();
    for (int j = 0; j < 16; j++) m_board[j] = 0;
    m_score = 0;
    m_prev = 0;
    m_win = 1'b0;
    @(negedge clk);
    check("reset_board", board, 64'd0);
    check("reset_score", 64'(score), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_moved", 64'(moved), 64'd0);
    check("reset_win", 64'(win), 64'd0);
    tick();
  endtask

  task automatic write_cell(input int idx, input int val);
    wr_en = 1'b1;
    wr_idx = 4'(idx);
    wr_val = 4'(val);
    tick();
    wr_en = 1'b0;
    m_board[idx] = val;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 30) begin
      tick();
      n++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL move_timeout actual=no done required=done within 30 cycles");
      exp_q.delete();
    end
    tick();
    tick();
  endtask

  // Drive a code (optionally together with a tile write) and predict the outcome.
  task automatic do_move(input int code, input bit with_wr, input int widx, input int wval);
    bit   acc;
    exp_t e;
    int   start;
    movement = 3'(code);
    start = cyc;
    if (with_wr) begin
      wr_en = 1'b1;
      wr_idx = 4'(widx);
      wr_val = 4'(wval);
      m_board[widx] = wval;
    end
    acc = (code >= 1 && code <= 4 && code != m_prev && !m_win);
    if (acc) begin
`ifdef MOVE_EXEC_UNDO_EN
      s_board = m_board;
      s_score = m_score;
      s_valid = 1'b1;
`endif
      e.moved = model_move(code);
      e.board = model_board();
      e.score = m_score;
      e.done_cyc = start + (with_wr ? 6 : 5);
      exp_q.push_back(e);
    end
    m_prev = code;
    tick();
    wr_en = 1'b0;
    wait_idle();
    if (acc) begin
      for (int j = 0; j < 16; j++) if (m_board[j] >= 11) m_win = 1'b1;
    end
    check("win", 64'(win), 64'(m_win));
    check("idle_board", board, model_board());
  endtask

  // Monitor: busy must be high during the four line cycles; compare at done.
  always @(negedge clk) begin
    if (!rst) begin
      if (exp_q.size() > 0 && cyc >= exp_q[0].done_cyc - 4 && cyc < exp_q[0].done_cyc)
        check("busy_during_move", 64'(busy), 64'd1);
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=done required=no done (cycle %0d)", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("done_cycle", 64'(cyc), 64'(mon_e.done_cyc));
          check("board", board, mon_e.board);
          check("score", 64'(score), 64'(mon_e.score));
          check("moved", 64'(moved), 64'(mon_e.moved));
          check("busy_at_done", 64'(busy), 64'd0);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    movement = 3'd0;
    wr_en = 1'b0;
    wr_idx = 4'd0;
    wr_val = 4'd0;
`ifdef MOVE_EXEC_UNDO_EN
    undo = 1'b0;
`endif
    do_reset();

    // Slide LEFT with one merge.
    write_cell(0, 1); write_cell(1, 1); write_cell(2, 2);
    do_move(1, 1'b0, 0, 0);

`ifdef MOVE_EXEC_UNDO_EN
    undo = 1'b1;
    tick();
    undo = 1'b0;
    if (s_valid) begin
      m_board = s_board;
      m_score = s_score;
      s_valid = 1'b0;
    end
    tick();
    check("undo_board", board, model_board());
    check("undo_score", 64'(score), 64'(m_score));
`endif

    // Held code runs once; then RIGHT.
    do_move(1, 1'b0, 0, 0);
    repeat (10) tick();
    check("held_busy", 64'(busy), 64'd0);
    do_move(2, 1'b0, 0, 0);

    // Column UP.
    write_cell(0, 1); write_cell(4, 0); write_cell(8, 1); write_cell(12, 1);
    do_move(3, 1'b0, 0, 0);

    // Reach the win tile; further codes are ignored until reset.
    write_cell(0, 10); write_cell(1, 10);
    do_move(1, 1'b0, 0, 0);
    do_move(2, 1'b0, 0, 0);
    do_move(4, 1'b0, 0, 0);
    do_reset();

    // Write coincident with a new code delays the move by one cycle.
    write_cell(5, 2);
    do_move(4, 1'b1, 9, 2);

    // Exponent 15 saturates: no merge, no change.
    do_reset();
    write_cell(0, 15); write_cell(1, 15);
    do_move(1, 1'b0, 0, 0);

    // Reset in the middle of a move discards it.
    do_reset();
    write_cell(0, 1); write_cell(1, 1);
    movement = 3'd1;
    tick(); tick(); tick();
    do_reset();

    // Randomized moves and writes.
    for (int n = 0; n < 80; n++) begin
      int nw;
      nw = $urandom_range(0, 2);
      for (int k = 0; k < nw; k++)
        write_cell($urandom_range(0, 15), ($urandom_range(0, 9) == 0) ? $urandom_range(7, 10)
                                                                      : $urandom_range(0, 4));
      do_move($urandom_range(0, 7), ($urandom_range(0, 5) == 0), $urandom_range(0, 15),
              $urandom_range(0, 4));
      if (m_win) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
